cpu_step_ctrl: RTL and testbench

//  Consumes debounced push-button levels and produces the single-cycle CPU's clock-enable.

---
 rtl/cpu_ctrl_pkg.sv | 12 +
 rtl/key_sync_edge.sv | 30 +++
 rtl/cpu_step_ctrl.sv | 143 ++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU step/run clock-enable controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    STEP_IDLE = 2'd0,
    RUN       = 2'd1,
    HALTED    = 2'd2
  } state_e;

  localparam int DEFAULT_RUN_PERIOD = 25000000;

endpackage

// File: rtl/key_sync_edge.sv
// Synchronises an asynchronous key level and emits a registered one-cycle pulse on its rising edge.
module key_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   rise_r;

  // Synchroniser chain, edge history and registered rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= sync_r[SYNC_STAGES-1];
      rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Step/run controller producing the single-cycle CPU clock-enable and an executed-instruction count.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RUN_PERIOD  = DEFAULT_RUN_PERIOD,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_key,
  input  logic             mode_key,
  input  logic             halt,
  output logic             cpu_en,
  output logic             run_mode,
  output logic             halted,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int                PCNT_W    = $clog2(RUN_PERIOD);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(RUN_PERIOD - 1);

  logic              step_rise_s;
  logic              mode_rise_s;
  state_e            state_r;
  state_e            state_s;
  logic [PCNT_W-1:0] pcnt_r;
  logic [PCNT_W-1:0] pcnt_s;
  logic              pulse_s;
  logic              cpu_en_r;
  logic              run_mode_r;
  logic              halted_r;
  logic [CNT_W-1:0]  step_cnt_r;

  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (step_key),
    .rise  (step_rise_s)
  );

  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mode_key),
    .rise  (mode_rise_s)
  );

  // State and run-period counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= STEP_IDLE;
      pcnt_r  <= '0;
    end else begin
      state_r <= state_s;
      pcnt_r  <= pcnt_s;
    end
  end

  // Next state: halt outranks mode toggling; the period counter only runs while staying in RUN
  always_comb begin
    state_s = state_r;
    pcnt_s  = '0;
    case (state_r)
      STEP_IDLE: begin
        if (halt) begin
          state_s = HALTED;
        end else if (mode_rise_s) begin
          state_s = RUN;
        end else begin
          state_s = STEP_IDLE;
        end
      end
      RUN: begin
        if (halt) begin
          state_s = HALTED;
        end else if (mode_rise_s) begin
          state_s = STEP_IDLE;
        end else begin
          state_s = RUN;
          pcnt_s  = (pcnt_r == PCNT_LAST) ? '0 : pcnt_r + PCNT_W'(1'b1);
        end
      end
      HALTED: begin
        if (mode_rise_s && !halt) begin
          state_s = STEP_IDLE;
        end else begin
          state_s = HALTED;
        end
      end
      default: begin
        state_s = STEP_IDLE;
      end
    endcase
  end

  // Pulse decision: a step press or period tick, suppressed by halt or a mode toggle
  always_comb begin
    pulse_s = 1'b0;
    case (state_r)
      STEP_IDLE: begin
        if (!halt && !mode_rise_s && step_rise_s) begin
          pulse_s = 1'b1;
        end else begin
          pulse_s = 1'b0;
        end
      end
      RUN: begin
        if (!halt && !mode_rise_s && (pcnt_r == PCNT_LAST)) begin
          pulse_s = 1'b1;
        end else begin
          pulse_s = 1'b0;
        end
      end
      default: begin
        pulse_s = 1'b0;
      end
    endcase
  end

  // Registered outputs; status flags track the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_en_r   <= 1'b0;
      run_mode_r <= 1'b0;
      halted_r   <= 1'b0;
      step_cnt_r <= '0;
    end else begin
      cpu_en_r   <= pulse_s;
      run_mode_r <= (state_s == RUN);
      halted_r   <= (state_s == HALTED);
      if (pulse_s) begin
        step_cnt_r <= step_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign cpu_en   = cpu_en_r;
  assign run_mode = run_mode_r;
  assign halted   = halted_r;
  assign step_cnt = step_cnt_r;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: directed vector table, corner sequences and randomized run vs. a reference model.
module tb_cpu_step_ctrl;

  localparam int S = 2;
  localparam int P = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         step_key;
  logic         mode_key;
  logic         halt;
  logic         cpu_en;
  logic         run_mode;
  logic         halted;
  logic [W-1:0] step_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_step_ctrl #(.SYNC_STAGES(S), .RUN_PERIOD(P), .CNT_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_key (step_key),
    .mode_key (mode_key),
    .halt     (halt),
    .cpu_en   (cpu_en),
    .run_mode (run_mode),
    .halted   (halted),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: key sample history, behavioural mode and countdown to the next run tick
  typedef enum {M_STEP, M_RUN, M_HALT} mmode_e;
  logic [S+2:0] sh_m, mh_m;
  mmode_e       m_mode;
  int           m_left;
  logic         m_en;
  logic [W-1:0] m_cnt;

  task automatic model_reset();
    sh_m = '0; mh_m = '0; m_mode = M_STEP; m_left = 0; m_en = 1'b0; m_cnt = '0;
  endtask

  // A key level sampled at edge e-(S+1) that was low at e-(S+2) acts on the FSM at edge e
  task automatic model_edge();
    logic sr, mr;
    sh_m = {sh_m[S+1:0], step_key};
    mh_m = {mh_m[S+1:0], mode_key};
    sr = sh_m[S+1] & ~sh_m[S+2];
    mr = mh_m[S+1] & ~mh_m[S+2];
    m_en = 1'b0;
    if (halt) m_mode = M_HALT;
    else if (mr) begin
      if (m_mode == M_STEP) begin m_mode = M_RUN; m_left = P; end
      else m_mode = M_STEP;
    end
    else if (m_mode == M_STEP) m_en = sr;
    else if (m_mode == M_RUN) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_en = 1'b1; m_left = P; end
    end
    if (m_en) m_cnt = m_cnt + 4'd1;
  endtask

  function automatic int outs();
    return int'({cpu_en, run_mode, halted, step_cnt});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it
  task automatic cyc(input logic sk, input logic mk, input logic h);
    step_key = sk; mode_key = mk; halt = h;
    @(posedge clk);
    model_edge();
    #1;
    check("model", outs(), int'({m_en, m_mode == M_RUN, m_mode == M_HALT, m_cnt}));
  endtask

  // Asynchronous reset between edges, checked before any further clock edge
  task automatic do_reset();
    step_key = 1'b0; mode_key = 1'b0; halt = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("rst_async_outputs", outs(), 0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  typedef struct {
    logic sk, mk, h;
    logic en, run, hlt;
    logic [W-1:0] cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic sk, input logic mk, input logic h,
                              input logic en, input logic run, input logic hlt, input int cnt);
    vec_t v;
    v.sk = sk; v.mk = mk; v.h = h; v.en = en; v.run = run; v.hlt = hlt; v.cnt = W'(cnt);
    vecs.push_back(v);
  endfunction

  int   pulses;
  int   snap;
  logic rs, rm, rh;

  initial begin
    // Step press held 10 cycles: one pulse 3 cycles after the rise, then release
    for (int i = 0; i < 13; i++)
      add(i < 10, 1'b0, 1'b0, i == 3, 1'b0, 1'b0, (i >= 3) ? 1 : 0);
    // Mode press held 20 cycles: RUN from cycle 3, a pulse every 4th cycle from cycle 7; step presses ignored
    for (int i = 0; i < 20; i++)
      add((i >= 9) && (i <= 14), 1'b1, 1'b0, (i >= 7) && ((i - 7) % 4 == 0), i >= 3, 1'b0,
          1 + ((i >= 7) ? ((i - 7) / 4 + 1) : 0));

    rst_n = 1'b0; step_key = 1'b0; mode_key = 1'b0; halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", outs(), 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].sk, vecs[i].mk, vecs[i].h);
      check($sformatf("vec%0d", i), outs(),
            int'({vecs[i].en, vecs[i].run, vecs[i].hlt, vecs[i].cnt}));
    end

    // Second mode press leaves RUN and pulses stop
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b1, 1'b0);
    check("t2_run_off", int'(run_mode), 0);
    pulses = 0;
    repeat (10) begin cyc(1'b0, 1'b0, 1'b0); pulses += int'(cpu_en); end
    check("t2_pulses_stop", pulses, 0);

    // Halt in RUN, mode press ignored while halted, released by mode press after halt drops
    cyc(1'b0, 1'b1, 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0);
    check("t3_in_run", int'(run_mode), 1);
    snap = int'(step_cnt);
    cyc(1'b0, 1'b0, 1'b1);
    check("t3_halted_next", int'({run_mode, halted}), 1);
    repeat (6) cyc(1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    check("t3_stay_halted", int'({run_mode, halted}), 1);
    check("t3_no_pulse", int'(step_cnt), snap);
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    check("t3_to_step", int'({run_mode, halted}), 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // 17 step presses from zero: wraps 15 -> 0 and ends at 1
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      if (k == 16) check("t4_wrap_zero", int'(step_cnt), 0);
    end
    check("t4_final_cnt", int'(step_cnt), 1);

    // Step and mode rise together: RUN, step dropped
    pulses = 0;
    repeat (4) begin cyc(1'b1, 1'b1, 1'b0); pulses += int'(cpu_en); end
    check("t5_no_pulse", pulses, 0);
    check("t5_run", int'(run_mode), 1);
    snap = 0;

    // Async reset landing on a RUN pulse
    for (int k = 0; k < 12 && snap == 0; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (cpu_en) snap = 1;
    end
    check("t6_found_pulse", snap, 1);
    do_reset();
    pulses = 0;
    repeat (8) begin cyc(1'b0, 1'b0, 1'b0); pulses += int'(cpu_en); end
    check("t6_idle_no_pulse", pulses, 0);
    check("t6_step_idle", int'({run_mode, halted}), 0);

    // Randomized keys and halt against the model
    rs = 1'b0; rm = 1'b0; rh = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) rs = ~rs;
      if ($urandom_range(5) == 0) rm = ~rm;
      if ($urandom_range(15) == 0) rh = ~rh;
      cyc(rs, rm, rh);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
